// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath control path: primary opcodes,
// ALUOp class encodings and the packed control bundle produced by decode.
package mips_pkg;

  // Primary opcodes, instruction bits [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;

  // ALUOp classes handed to the ALU control block
  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_IMMLOG = 2'b11;

  // Control bundle; field order matches the decode table column order
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] alu_op;
  } ctrl_t;

  // All-zero bundle: no writes, no memory access, no control transfer
  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode-to-control-bundle decoder.
module control_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_code,
  output ctrl_t      ctrl
);

  // Decode table; anything unlisted (including X) falls to NOP
  always_comb begin
    ctrl = CTRL_NOP;
    case (op_code)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      // Link register and PC+4 write-back are chosen by the datapath
      OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LUI, OP_ORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_IMMLOG;
      end
      OP_ADDI, OP_ADDIU: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main decoder of the MIPS datapath: combinational decode followed by one
// output register so controls line up with the stage after decode.
module control_unit
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] OpCode,
  output logic       RegDst,
  output logic       ALUSrc,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic [1:0] ALUOp
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .op_code (OpCode),
    .ctrl    (ctrl_d)
  );

  // Output register; reset clears to NOP at once and drops any in-flight decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= CTRL_NOP;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign ALUSrc   = ctrl_q.alu_src;
  assign MemToReg = ctrl_q.mem_to_reg;
  assign RegWrite = ctrl_q.reg_write;
  assign MemRead  = ctrl_q.mem_read;
  assign MemWrite = ctrl_q.mem_write;
  assign Branch   = ctrl_q.branch;
  assign Jump     = ctrl_q.jump;
  assign ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the hand-computed
// bundle for each opcode; a monitor pops and compares one cycle later.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [5:0] OpCode;
  logic       RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump;
  logic [1:0] ALUOp;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [5:0] op;
    logic [9:0] exp;
  } item_t;

  item_t sb_q[$];

  control_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .OpCode   (OpCode),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .Jump     (Jump),
    .ALUOp    (ALUOp)
  );

  // {RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch Jump ALUOp}
  wire [9:0] got = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
                    Branch, Jump, ALUOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-entered decode table rows
  function automatic logic [9:0] expected_of(input logic [5:0] op);
    case (op)
      6'b000000: return 10'b1001000010; // R-type
      6'b100011: return 10'b0111100000; // LW
      6'b101011: return 10'b0100010000; // SW
      6'b000100: return 10'b0000001001; // BEQ
      6'b000010: return 10'b0000000100; // J
      6'b000011: return 10'b0001000100; // JAL
      6'b001111: return 10'b0101000011; // LUI
      6'b001101: return 10'b0101000011; // ORI
      6'b001000: return 10'b0101000000; // ADDI
      6'b001001: return 10'b0101000000; // ADDIU
      default:   return 10'b0000000000;
    endcase
  endfunction

  function automatic void check(input string name, input logic [9:0] act,
                                input logic [9:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endfunction

  // Drive an opcode before the next rising edge and record what must follow
  task automatic apply(input logic [5:0] op);
    item_t it;
    @(negedge clk);
    OpCode = op;
    it.op  = op;
    it.exp = expected_of(op);
    sb_q.push_back(it);
  endtask

  // Monitor: one edge after each push the registered bundle must match
  initial begin
    item_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        check($sformatf("decode op=%b", it.op), got, it.exp);
        $display("[TB] op=%b got=%b exp=%b", it.op, got, it.exp);
        check("memrd_memwr_exclusive", {9'b0, MemRead & MemWrite}, 10'b0);
        check("branch_jump_exclusive", {9'b0, Branch & Jump}, 10'b0);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n  = 1'b0;
    OpCode = 6'b000000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_nop", got, 10'b0);
    $display("[TB] reset held got=%b", got);

    // Release at a falling edge; first rising edge registers R-type
    rst_n = 1'b1;
    begin
      item_t it;
      it.op = 6'b000000; it.exp = 10'b1001000010;
      sb_q.push_back(it);
    end

    // Directed sweep of the defined opcodes
    apply(6'b100011); // LW
    apply(6'b101011); // SW
    apply(6'b000100); // BEQ
    apply(6'b000010); // J
    apply(6'b000011); // JAL
    apply(6'b001111); // LUI
    apply(6'b001101); // ORI
    apply(6'b001000); // ADDI
    apply(6'b001001); // ADDIU
    apply(6'b000000); // R-type

    // Undefined opcodes
    apply(6'b111111);
    apply(6'b000001);
    apply(6'b100000);

    // Exhaustive sweep
    for (int i = 0; i < 64; i++) begin
      apply(6'(i));
    end

    // Asynchronous reset mid-stream
    apply(6'b100011); // LW
    @(posedge clk);   // monitor checks LW bundle at this edge
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_immediate", got, 10'b0);
    $display("[TB] async reset between edges got=%b", got);
    @(posedge clk);
    #1;
    check("reset_held_through_edge", got, 10'b0);
    $display("[TB] reset through edge got=%b", got);
    @(negedge clk);
    check("reset_before_release", got, 10'b0);
    rst_n = 1'b1;
    begin
      item_t it;
      it.op = 6'b100011; it.exp = 10'b0111100000;
      sb_q.push_back(it);
    end

    repeat (3) @(posedge clk);
    #2;
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d left required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
